// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbitration of two byte requesters into a small
// FIFO, followed by an 8N1 serializer paced by the baud-rate tick.
module uart_tx_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               txclk_en_i,
  input  logic               req0_valid_i,
  input  logic [7:0]         req0_data_i,
  output logic               req0_ready_o,
  input  logic               req1_valid_i,
  input  logic [7:0]         req1_data_i,
  output logic               req1_ready_o,
  output logic               tx_o,
  output logic               busy_o,
  output logic [FIFO_AW:0]   fifo_cnt_o,
  output logic               last_grant_o
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = (FIFO_AW)'(1);

  state_t               state, state_nxt;
  logic [7:0]           fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     fifo_cnt;
  logic [7:0]           shift, shift_nxt;
  logic [2:0]           bit_cnt, bit_cnt_nxt;
  logic                 tx_q, tx_nxt;
  logic                 last_grant;
  logic                 full, has_data;
  logic                 ready0, ready1;
  logic                 push, pop;
  logic [7:0]           push_data;

  // Round-robin arbiter: fullness comes only from the registered count, so a
  // pop in the same cycle never opens a slot early.
  always_comb begin
    full      = (fifo_cnt == DEPTH_CNT);
    has_data  = (fifo_cnt != '0);
    ready0    = 1'b0;
    ready1    = 1'b0;
    if (!full) begin
      if (req0_valid_i && req1_valid_i) begin
        ready0 = last_grant;
        ready1 = !last_grant;
      end else begin
        ready0 = req0_valid_i;
        ready1 = req1_valid_i;
      end
    end
    push      = ready0 | ready1;
    push_data = ready1 ? req1_data_i : req0_data_i;
  end

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers, occupancy and the grant history used for tie-breaking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      last_grant <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_ONE;
        last_grant <= ready1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Serializer state register; the line output is registered so the tick has
  // no combinational path to the pin.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      tx_q    <= 1'b1;
      shift   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tx_q    <= tx_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  // Serializer next-state logic: every transition waits for a baud tick, and
  // STOP can chain straight into the next start bit when data is waiting.
  always_comb begin
    state_nxt   = state;
    tx_nxt      = tx_q;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (txclk_en_i && has_data) begin
          pop       = 1'b1;
          shift_nxt = fifo_mem[rd_ptr];
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (txclk_en_i) begin
          tx_nxt      = shift[0];
          shift_nxt   = {1'b0, shift[7:1]};
          bit_cnt_nxt = 3'd0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (txclk_en_i) begin
          if (bit_cnt != 3'd7) begin
            tx_nxt      = shift[0];
            shift_nxt   = {1'b0, shift[7:1]};
            bit_cnt_nxt = bit_cnt + 3'd1;
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (txclk_en_i) begin
          if (has_data) begin
            pop       = 1'b1;
            shift_nxt = fifo_mem[rd_ptr];
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  assign req0_ready_o = ready0;
  assign req1_ready_o = ready1;
  assign tx_o         = tx_q;
  assign busy_o       = (state != IDLE);
  assign fifo_cnt_o   = fifo_cnt;
  assign last_grant_o = last_grant;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed scenarios for arbitration, FIFO boundaries and
// 8N1 framing of uart_tx_sched.
module tb_uart_tx_sched;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       txclk_en_i;
  logic       req0_valid_i;
  logic [7:0] req0_data_i;
  logic       req0_ready_o;
  logic       req1_valid_i;
  logic [7:0] req1_data_i;
  logic       req1_ready_o;
  logic       tx_o;
  logic       busy_o;
  logic [2:0] fifo_cnt_o;
  logic       last_grant_o;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_sched #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .txclk_en_i   (txclk_en_i),
    .req0_valid_i (req0_valid_i),
    .req0_data_i  (req0_data_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_data_i  (req1_data_i),
    .req1_ready_o (req1_ready_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .fifo_cnt_o   (fifo_cnt_o),
    .last_grant_o (last_grant_o)
  );

  // 10 ns system clock.
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i        = 1'b1;
    txclk_en_i   = 1'b0;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    req0_data_i  = 8'h00;
    req1_data_i  = 8'h00;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic push_byte(input bit sel, input logic [7:0] data);
    if (sel) begin
      req1_valid_i = 1'b1;
      req1_data_i  = data;
    end else begin
      req0_valid_i = 1'b1;
      req0_data_i  = data;
    end
    step();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
  endtask

  // Captures one frame with txclk_en_i held high; entered while the start bit
  // is on the line, returns while the next frame's start bit (or idle) shows.
  task automatic receive_frame(output logic [7:0] data, output logic framing_ok);
    logic start_ok;
    start_ok = (tx_o === 1'b0);
    for (int b = 0; b < 8; b++) begin
      step();
      data[b] = tx_o;
    end
    step();
    framing_ok = start_ok && (tx_o === 1'b1);
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (tx_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tx: got %b expected 1", tx_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    vectors++; if (fifo_cnt_o !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_cnt: got %0d expected 0", fifo_cnt_o); end
    vectors++; if (last_grant_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_last_grant: got %b expected 1", last_grant_o); end
    vectors++; if ({req0_ready_o, req1_ready_o} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 00", {req0_ready_o, req1_ready_o}); end
    txclk_en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if ({busy_o, tx_o} !== 2'b01) begin miscompares++; $display("[TB] FAIL idle_tick_ignored: got busy,tx=%b expected 01", {busy_o, tx_o}); end
    end
    txclk_en_i = 1'b0;
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    logic       exp_tx;
    logic       exp_busy;
    frame = {1'b1, 8'hA5, 1'b0};
    apply_reset();
    req0_valid_i = 1'b1;
    req0_data_i  = 8'hA5;
    #1;
    vectors++; if ({req0_ready_o, req1_ready_o} !== 2'b10) begin miscompares++; $display("[TB] FAIL single_ready: got %b expected 10", {req0_ready_o, req1_ready_o}); end
    step();
    req0_valid_i = 1'b0;
    vectors++; if (fifo_cnt_o !== 3'd1) begin miscompares++; $display("[TB] FAIL single_cnt_push: got %0d expected 1", fifo_cnt_o); end
    vectors++; if (last_grant_o !== 1'b0) begin miscompares++; $display("[TB] FAIL single_last_grant: got %b expected 0", last_grant_o); end
    for (int c = 0; c < 44; c++) begin
      txclk_en_i = (c % 4 == 0);
      step();
      exp_tx   = (c < 40) ? frame[c / 4] : 1'b1;
      exp_busy = (c < 40);
      vectors++; if (tx_o !== exp_tx) begin miscompares++; $display("[TB] FAIL single_tx cycle %0d: got %b expected %b", c, tx_o, exp_tx); end
      vectors++; if (busy_o !== exp_busy) begin miscompares++; $display("[TB] FAIL single_busy cycle %0d: got %b expected %b", c, busy_o, exp_busy); end
      if (c == 0) begin
        vectors++; if (fifo_cnt_o !== 3'd0) begin miscompares++; $display("[TB] FAIL single_cnt_pop: got %0d expected 0", fifo_cnt_o); end
      end
    end
    txclk_en_i = 1'b0;
  endtask

  task automatic test_round_robin();
    apply_reset();
    req0_valid_i = 1'b1;
    req0_data_i  = 8'h11;
    req1_valid_i = 1'b1;
    req1_data_i  = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if ({req0_ready_o, req1_ready_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin miscompares++; $display("[TB] FAIL rr_ready accept %0d: got %b expected %b", i, {req0_ready_o, req1_ready_o}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      step();
      vectors++; if (fifo_cnt_o !== 3'(i + 1)) begin miscompares++; $display("[TB] FAIL rr_cnt accept %0d: got %0d expected %0d", i, fifo_cnt_o, i + 1); end
      vectors++; if (last_grant_o !== 1'(i % 2)) begin miscompares++; $display("[TB] FAIL rr_last_grant accept %0d: got %b expected %0d", i, last_grant_o, i % 2); end
    end
    #1;
    vectors++; if ({req0_ready_o, req1_ready_o} !== 2'b00) begin miscompares++; $display("[TB] FAIL rr_full_ready: got %b expected 00", {req0_ready_o, req1_ready_o}); end
  endtask

  // Continues from the full FIFO left by test_round_robin.
  task automatic test_full_boundary();
    logic [7:0] exp_bytes [5];
    logic [7:0] data;
    logic       ok;
    exp_bytes = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h33};
    txclk_en_i = 1'b1;
    #1;
    vectors++; if ({req0_ready_o, req1_ready_o} !== 2'b00) begin miscompares++; $display("[TB] FAIL full_ready_in_pop: got %b expected 00", {req0_ready_o, req1_ready_o}); end
    step();
    txclk_en_i = 1'b0;
    vectors++; if (fifo_cnt_o !== 3'd3) begin miscompares++; $display("[TB] FAIL full_cnt_after_pop: got %0d expected 3", fifo_cnt_o); end
    vectors++; if ({busy_o, tx_o} !== 2'b10) begin miscompares++; $display("[TB] FAIL full_frame_start: got busy,tx=%b expected 10", {busy_o, tx_o}); end
    req0_data_i = 8'h33;
    #1;
    vectors++; if ({req0_ready_o, req1_ready_o} !== 2'b10) begin miscompares++; $display("[TB] FAIL full_ready_after_pop: got %b expected 10", {req0_ready_o, req1_ready_o}); end
    step();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    vectors++; if (fifo_cnt_o !== 3'd4) begin miscompares++; $display("[TB] FAIL full_cnt_refill: got %0d expected 4", fifo_cnt_o); end
    vectors++; if (last_grant_o !== 1'b0) begin miscompares++; $display("[TB] FAIL full_last_grant: got %b expected 0", last_grant_o); end
    txclk_en_i = 1'b1;
    for (int f = 0; f < 5; f++) begin
      receive_frame(data, ok);
      vectors++; if (data !== exp_bytes[f] || !ok) begin miscompares++; $display("[TB] FAIL full_drain frame %0d: got %h framing %b expected %h framing 1", f, data, ok, exp_bytes[f]); end
    end
    vectors++; if ({busy_o, tx_o, fifo_cnt_o} !== {1'b0, 1'b1, 3'd0}) begin miscompares++; $display("[TB] FAIL full_drain_idle: got busy,tx,cnt=%b expected 0,1,000", {busy_o, tx_o, fifo_cnt_o}); end
    txclk_en_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp_line;
    exp_line = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    apply_reset();
    push_byte(1'b0, 8'h00);
    push_byte(1'b1, 8'hFF);
    vectors++; if (fifo_cnt_o !== 3'd2) begin miscompares++; $display("[TB] FAIL b2b_cnt: got %0d expected 2", fifo_cnt_o); end
    txclk_en_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++; if ({busy_o, tx_o} !== {1'b1, exp_line[i]}) begin miscompares++; $display("[TB] FAIL b2b_line cycle %0d: got busy,tx=%b expected 1%b", i, {busy_o, tx_o}, exp_line[i]); end
    end
    step();
    vectors++; if ({busy_o, tx_o} !== 2'b01) begin miscompares++; $display("[TB] FAIL b2b_end: got busy,tx=%b expected 01", {busy_o, tx_o}); end
    txclk_en_i = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    push_byte(1'b0, 8'h52);
    push_byte(1'b1, 8'h3C);
    push_byte(1'b0, 8'h77);
    vectors++; if ({fifo_cnt_o, last_grant_o} !== {3'd3, 1'b0}) begin miscompares++; $display("[TB] FAIL midrst_setup: got cnt,grant=%b expected 0110", {fifo_cnt_o, last_grant_o}); end
    txclk_en_i = 1'b1;
    step();
    vectors++; if (fifo_cnt_o !== 3'd2) begin miscompares++; $display("[TB] FAIL midrst_cnt: got %0d expected 2", fifo_cnt_o); end
    for (int i = 0; i < 4; i++) step();
    vectors++; if ({busy_o, tx_o} !== 2'b10) begin miscompares++; $display("[TB] FAIL midrst_bit3: got busy,tx=%b expected 10", {busy_o, tx_o}); end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    vectors++; if (tx_o !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_tx: got %b expected 1", tx_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy_o); end
    vectors++; if (fifo_cnt_o !== 3'd0) begin miscompares++; $display("[TB] FAIL midrst_cnt_cleared: got %0d expected 0", fifo_cnt_o); end
    vectors++; if (last_grant_o !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_last_grant: got %b expected 1", last_grant_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if ({busy_o, tx_o, fifo_cnt_o} !== {1'b0, 1'b1, 3'd0}) begin miscompares++; $display("[TB] FAIL midrst_no_frame: got busy,tx,cnt=%b expected 0,1,000", {busy_o, tx_o, fifo_cnt_o}); end
    end
    txclk_en_i = 1'b0;
  endtask

  task automatic test_push_pop();
    logic [7:0] exp_bytes [3];
    logic [7:0] data;
    logic       ok;
    exp_bytes = '{8'h81, 8'h42, 8'h99};
    apply_reset();
    push_byte(1'b0, 8'h81);
    push_byte(1'b1, 8'h42);
    vectors++; if (fifo_cnt_o !== 3'd2) begin miscompares++; $display("[TB] FAIL pp_setup_cnt: got %0d expected 2", fifo_cnt_o); end
    req1_valid_i = 1'b1;
    req1_data_i  = 8'h99;
    txclk_en_i   = 1'b1;
    #1;
    vectors++; if ({req0_ready_o, req1_ready_o} !== 2'b01) begin miscompares++; $display("[TB] FAIL pp_ready: got %b expected 01", {req0_ready_o, req1_ready_o}); end
    step();
    req1_valid_i = 1'b0;
    vectors++; if (fifo_cnt_o !== 3'd2) begin miscompares++; $display("[TB] FAIL pp_cnt: got %0d expected 2", fifo_cnt_o); end
    vectors++; if ({busy_o, tx_o, last_grant_o} !== 3'b101) begin miscompares++; $display("[TB] FAIL pp_state: got busy,tx,grant=%b expected 101", {busy_o, tx_o, last_grant_o}); end
    for (int f = 0; f < 3; f++) begin
      receive_frame(data, ok);
      vectors++; if (data !== exp_bytes[f] || !ok) begin miscompares++; $display("[TB] FAIL pp_frame %0d: got %h framing %b expected %h framing 1", f, data, ok, exp_bytes[f]); end
    end
    vectors++; if ({busy_o, tx_o} !== 2'b01) begin miscompares++; $display("[TB] FAIL pp_end: got busy,tx=%b expected 01", {busy_o, tx_o}); end
    txclk_en_i = 1'b0;
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_full_boundary();
    test_back_to_back();
    test_reset_mid_frame();
    test_push_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
